// File: rtl/alu_pipe_pkg.sv
// Shared types and constants for the alu_pipe block: opcode and FSM state
// enums, flag bit positions, and a helper that packs the four flag bits.
// The optional macro ALU_PIPE_BARREL_EN is consumed by alu_pipe and
// alu_pipe_core, not here.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ZERO   = 4'h0,
    OP_PASSA  = 4'h1,
    OP_PASSB  = 4'h2,
    OP_NOTA   = 4'h3,
    OP_INCA   = 4'h4,
    OP_INCB   = 4'h5,
    OP_DECA   = 4'h6,
    OP_ADD    = 4'h7,
    OP_SUB    = 4'h8,
    OP_AND    = 4'h9,
    OP_OR     = 4'hA,
    OP_XOR    = 4'hB,
    OP_SHL    = 4'hC,
    OP_SHR    = 4'hD,
    OP_BSWAP  = 4'hE,
    OP_PARITY = 4'hF
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit positions inside flags = {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational result/flag datapath for every single-cycle operation.
// With ALU_PIPE_BARREL_EN defined the shifts are full barrel shifts;
// otherwise only shift amounts 0 and 1 are resolved here and alu_pipe
// sequences larger amounts one bit per cycle.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  op_e              w_op;
  logic [SHW-1:0]   w_amt;
  logic             w_oor;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  // Shift vectors carry one extra bit holding the last bit shifted out:
  // bit WIDTH for left shifts, bit 0 for right shifts.
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign w_op  = op_e'(opcode);
  assign w_amt = b[SHW-1:0];
  assign w_oor = |b[WIDTH-1:SHW];

  // Operand selection for the shared adder/subtractor (opcodes 4..8)
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_x   = a;
    w_y   = b;
    w_sub = 1'b0;
    case (w_op)
      OP_INCA: w_y = WIDTH'(1);
      OP_INCB: begin w_x = b; w_y = WIDTH'(1); end
      OP_DECA: begin w_y = WIDTH'(1); w_sub = 1'b1; end
      OP_SUB:  w_sub = 1'b1;
      default: ;
    endcase
  end

  // Bit WIDTH of the widened sum is carry-out for add, borrow-out for sub
  assign w_sum = w_sub ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});
  assign w_ovf = w_sub ? ((w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]))
                       : ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]));

`ifdef ALU_PIPE_BARREL_EN
  assign w_shl = {1'b0, a} << w_amt;
  assign w_shr = {a, 1'b0} >> w_amt;
`else
  assign w_shl = (w_amt == SHW'(1)) ? {a, 1'b0} : {1'b0, a};
  assign w_shr = (w_amt == SHW'(1)) ? {1'b0, a} : {a, 1'b0};
`endif

  // Byte-order reverse of A
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      w_rev[8*i +: 8] = a[WIDTH-8-8*i +: 8];
    end
  end

  // Result, carry and overflow per opcode
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ZERO:   w_res = '0;
      OP_PASSA:  w_res = a;
      OP_PASSB:  w_res = b;
      OP_NOTA:   w_res = ~a;
      OP_INCA, OP_INCB, OP_DECA, OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf;
      end
      OP_AND:    w_res = a & b;
      OP_OR:     w_res = a | b;
      OP_XOR:    w_res = a ^ b;
      OP_SHL: if (!w_oor) begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: if (!w_oor) begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_BSWAP:  w_res = w_rev;
      OP_PARITY: w_res = {{(WIDTH-1){1'b0}}, ^a};
      default:   w_res = '0;
    endcase
  end

  assign result = w_res;
  assign flags  = pack_flags(w_res[WIDTH-1], w_res == '0, w_c, w_v);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with a registered result and {N,Z,C,V} flags.
// Default build shifts by more than one bit iteratively (one bit per cycle in
// ST_SHIFT); defining ALU_PIPE_BARREL_EN makes every opcode single-cycle and
// removes the FSM. Results and flags are identical in both builds.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic             r_init;       // low in reset, high from the first edge after release
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic             w_accept;
  logic [WIDTH-1:0] w_core_result;
  logic [3:0]       w_core_flags;

  alu_pipe_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .result (w_core_result),
    .flags  (w_core_flags)
  );

`ifdef ALU_PIPE_BARREL_EN
  assign in_ready = r_init && (!r_out_valid || out_ready);
`else
  state_e           r_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH:0]   r_work;       // same extended layout as the core's shift vectors
  logic             r_left;
  logic             w_go_iter;
  logic [WIDTH:0]   w_step;
  logic [WIDTH-1:0] w_fin_res;
  logic             w_fin_c;

  assign in_ready  = r_init && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_go_iter = ((op_e'(opcode) == OP_SHL) || (op_e'(opcode) == OP_SHR)) &&
                     !(|b[WIDTH-1:SHW]) && (b[SHW-1:0] > SHW'(1));
  assign w_step    = r_left ? {r_work[WIDTH-1:0], 1'b0} : {1'b0, r_work[WIDTH:1]};
  assign w_fin_res = r_left ? w_step[WIDTH-1:0] : w_step[WIDTH:1];
  assign w_fin_c   = r_left ? w_step[WIDTH] : w_step[0];
`endif

  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  // Handshake, output register and (default build) iterative shift FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init      <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
`ifndef ALU_PIPE_BARREL_EN
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_left      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values;
      // a later assignment in this block overrides the consume-clear below.
      r_init <= 1'b1;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
`ifdef ALU_PIPE_BARREL_EN
      if (w_accept) begin
        r_result    <= w_core_result;
        r_flags     <= w_core_flags;
        r_out_valid <= 1'b1;
      end
`else
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_go_iter) begin
              // First bit is shifted on the accept edge; the counter covers the rest.
              r_left  <= (op_e'(opcode) == OP_SHL);
              r_work  <= (op_e'(opcode) == OP_SHL) ? {a, 1'b0} : {1'b0, a};
              r_cnt   <= b[SHW-1:0] - SHW'(2);
              r_state <= ST_SHIFT;
            end else begin
              r_result    <= w_core_result;
              r_flags     <= w_core_flags;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (r_cnt == '0) begin
            r_result    <= w_fin_res;
            r_flags     <= pack_flags(w_fin_res[WIDTH-1], w_fin_res == '0, w_fin_c, 1'b0);
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_work <= w_step;
            r_cnt  <= r_cnt - SHW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32): the driver pushes the hand-computed
// expected result/flags when a beat is accepted; a monitor pops and compares
// whenever a result is consumed. Latency expectations follow ALU_PIPE_BARREL_EN.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 32;
`ifdef ALU_PIPE_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   fl;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] res;
    logic [3:0]   fl;   // {N,Z,C,V}
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one beat, holding it until accepted; expectation is queued at acceptance.
  task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] er, input logic [3:0] ef);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    opcode   = op;
    a        = av;
    b        = bv;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_within_bound", in_ready, 1'b1);
    if (in_ready) exp_q.push_back('{res: er, fl: ef});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send one beat, then measure cycles to out_valid and cycles with in_ready low.
  task automatic send_lat(input string name, input logic [3:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] er, input logic [3:0] ef,
                          input int exp_lat, input int exp_lows);
    int lat;
    int lows;
    lat  = 0;
    lows = 0;
    send(op, av, bv, er, ef);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
      if (!in_ready) lows++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_ready_low"}, lows, exp_lows);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare consumed results with the scoreboard, and check that a
  // stalled result holds stable.
  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_res;
  logic [3:0]   hold_fl;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_result", result, hold_res);
        check("hold_flags", flags, hold_fl);
      end
      if (out_valid) begin
        if (out_ready) begin
          exp_t e;
          n_out++;
          check("sb_expectation_present", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_result", result, e.res);
            check("sb_flags", flags, e.fl);
          end
        end
        hold_prev = !out_ready;
        hold_res  = result;
        hold_fl   = flags;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  vec_t vecs [14] = '{
    '{OP_ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110},
    '{OP_SUB,    32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001},
    '{OP_ZERO,   32'h00000123, 32'h00000456, 32'h00000000, 4'b0100},
    '{OP_PASSA,  32'h80000001, 32'h00000000, 32'h80000001, 4'b1000},
    '{OP_PASSB,  32'h00000009, 32'h00000005, 32'h00000005, 4'b0000},
    '{OP_NOTA,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1000},
    '{OP_INCA,   32'h7FFFFFFF, 32'h00000000, 32'h80000000, 4'b1001},
    '{OP_INCB,   32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b0110},
    '{OP_DECA,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1010},
    '{OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000},
    '{OP_OR,     32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b1000},
    '{OP_XOR,    32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0100},
    '{OP_BSWAP,  32'h11223344, 32'h00000000, 32'h44332211, 4'b0000},
    '{OP_SUB,    32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b1010}
  };

  initial begin
    int n0;
    in_valid  = 1'b0;
    opcode    = 4'h0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_flags", flags, 4'h0);
    check("rst_in_ready", in_ready, 1'b0);

    // in_ready must wait for a clock edge after release
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_at_release", in_ready, 1'b0);
    @(negedge clk);
    check("ready_after_first_edge", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Single-cycle opcodes, back to back
    foreach (vecs[i]) send(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].res, vecs[i].fl);
    send(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
    send(OP_PARITY, 32'h00000007, 32'h0, 32'h00000001, 4'b0000);
    repeat (3) @(posedge clk);
    #1;

    // Shifts: latency and in_ready behaviour
    send_lat("shl_1_by_5", OP_SHL, 32'h1, 32'd5, 32'h20, 4'b0000,
             BARREL ? 1 : 5, BARREL ? 0 : 4);
    send_lat("shr_oor", OP_SHR, 32'hF0, 32'h40, 32'h0, 4'b0100, 1, 0);
    send_lat("shl_by_1", OP_SHL, 32'h80000001, 32'd1, 32'h00000002, 4'b0010, 1, 0);
    send_lat("shl_by_0", OP_SHL, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 4'b1000, 1, 0);
    send_lat("shr_3_by_2", OP_SHR, 32'h3, 32'd2, 32'h0, 4'b0110,
             BARREL ? 1 : 2, BARREL ? 0 : 1);
    send_lat("shr_msb_by_31", OP_SHR, 32'h80000000, 32'd31, 32'h1, 4'b0000,
             BARREL ? 1 : 31, BARREL ? 0 : 30);

    // Back-pressure: first result held, second beat waits, nothing lost
    n0        = n_out;
    out_ready = 1'b0;
    send(OP_PASSA, 32'hA1, 32'h0, 32'hA1, 4'b0000);
    in_valid = 1'b1;
    opcode   = OP_PASSA;
    a        = 32'hA2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_out_valid_high", out_valid, 1'b1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(OP_PASSA, 32'hA2, 32'h0, 32'hA2, 4'b0000);
    send(OP_PASSA, 32'hA3, 32'h0, 32'hA3, 4'b0000);
    repeat (3) @(negedge clk);
    check("bp_results_delivered", n_out - n0, 3);

    // Reset during a 20-bit shift abandons it
    @(posedge clk);
    #1;
    send(OP_SHL, 32'h1, 32'd20, 32'h00100000, 4'b0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_result", result, '0);
    check("midrst_flags", flags, 4'h0);
    check("midrst_in_ready", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    n0 = n_out;
    repeat (30) @(negedge clk);
    check("midrst_no_stray_result", n_out, n0);
    check("midrst_idle_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    send(OP_PARITY, 32'h7, 32'h0, 32'h1, 4'b0000);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
